pc_sequencer: RTL and testbench

- Controls the 32-bit program counter register. Generates its write-enable, add-select, count-enable and data inputs, and runs the instruction-fetch request/acknowledge handshake.
- Arbitrates redirect sources (trap, jump, branch) against sequential fetch and pipeline stall.
- Sits between the decode/execute stage, the PC register and the instruction memory port.

---
 rtl/pc_pkg.sv | 30 +++
 rtl/redirect_arbiter.sv | 49 ++++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer and its arbiter.
package pc_pkg;

   localparam int          XLEN_DEFAULT        = 32;
   localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0010;
   localparam logic [31:0] PC_INCREMENT        = 32'd4;

   // Sequencer states; BOOT is the reset state.
   typedef enum logic [2:0] {
      BOOT     = 3'd0,
      FETCH    = 3'd1,
      STALL    = 3'd2,
      DRAIN    = 3'd3,
      REDIRECT = 3'd4
   } seqState_t;

   // Redirect kinds; the numeric value is the priority (higher wins).
   typedef enum logic [1:0] {
      NONE   = 2'd0,
      BRANCH = 2'd1,
      JUMP   = 2'd2,
      TRAP   = 2'd3
   } redirectKind_t;

   // True when kind a strictly outranks kind b; ties keep the incumbent.
   function automatic logic outranks(redirectKind_t a, redirectKind_t b);
      return a > b;
   endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Combinational priority selection between this cycle's redirect pulses and
// the redirect already held pending by the sequencer.
module redirect_arbiter
   import pc_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
   input  logic        trapValid,
   input  logic        jumpValid,
   input  logic [31:0] jumpTarget,
   input  logic        branchTaken,
   input  logic [31:0] branchOffset,
   input  logic [1:0]  pendingKind,
   input  logic [31:0] pendingValue,
   output logic        incomingValid,
   output logic [1:0]  selectedKind,
   output logic [31:0] selectedValue
);

   redirectKind_t incomingKind;
   logic [31:0]   incomingValue;

   // Encode the simultaneous pulses (trap > jump > branch), then merge with pending.
   always_comb begin
      incomingKind  = NONE;
      incomingValue = '0;
      if (trapValid) begin
         incomingKind  = TRAP;
         incomingValue = TRAP_VECTOR;
      end else if (jumpValid) begin
         incomingKind  = JUMP;
         incomingValue = jumpTarget;
      end else if (branchTaken) begin
         incomingKind  = BRANCH;
         incomingValue = branchOffset;
      end

      incomingValid = (incomingKind != NONE);

      if (outranks(incomingKind, redirectKind_t'(pendingKind))) begin
         selectedKind  = incomingKind;
         selectedValue = incomingValue;
      end else begin
         selectedKind  = pendingKind;
         selectedValue = pendingValue;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the PC register strobes and runs the
// instruction-fetch request/acknowledge handshake, folding in redirects.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
   parameter int          XLEN        = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imemReq,
   input  logic            imemAck,
   input  logic            stall,
   input  logic            branchTaken,
   input  logic [XLEN-1:0] branchOffset,
   input  logic            jumpValid,
   input  logic [XLEN-1:0] jumpTarget,
   input  logic            trapValid,
   output logic            pcWriteEnable,
   output logic            pcWriteAdd,
   output logic            pcCountEnable,
   output logic [XLEN-1:0] pcDataIn,
   output logic            flush,
   output logic            busy
);

   seqState_t     stateReg, stateNext;
   redirectKind_t pendKindReg, pendKindNext;
   logic [31:0]   pendValueReg, pendValueNext;

   logic          redirectIn;
   logic [1:0]    selKind;
   logic [31:0]   selValue;

   redirect_arbiter #(
      .TRAP_VECTOR (TRAP_VECTOR)
   ) arbiter (
      .trapValid     (trapValid),
      .jumpValid     (jumpValid),
      .jumpTarget    (jumpTarget),
      .branchTaken   (branchTaken),
      .branchOffset  (branchOffset),
      .pendingKind   (pendKindReg),
      .pendingValue  (pendValueReg),
      .incomingValid (redirectIn),
      .selectedKind  (selKind),
      .selectedValue (selValue)
   );

   // State and pending-redirect registers; reset abandons any outstanding fetch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg     <= BOOT;
         pendKindReg  <= NONE;
         pendValueReg <= '0;
      end else begin
         stateReg     <= stateNext;
         pendKindReg  <= pendKindNext;
         pendValueReg <= pendValueNext;
      end
   end

   // Next-state and pending-redirect update; redirects are only heard in FETCH, DRAIN and STALL.
   always_comb begin
      stateNext     = stateReg;
      pendKindNext  = pendKindReg;
      pendValueNext = pendValueReg;
      case (stateReg)
         BOOT: begin
            stateNext = FETCH;
         end
         FETCH: begin
            if (redirectIn) begin
               pendKindNext  = redirectKind_t'(selKind);
               pendValueNext = selValue;
               // With an ack the fetch is already back and gets flushed; otherwise wait it out.
               stateNext     = imemAck ? REDIRECT : DRAIN;
            end else if (imemAck && stall) begin
               stateNext = STALL;
            end
         end
         DRAIN: begin
            // The arbiter keeps the pending redirect unless a strictly higher one arrives.
            pendKindNext  = redirectKind_t'(selKind);
            pendValueNext = selValue;
            if (imemAck) begin
               stateNext = REDIRECT;
            end
         end
         STALL: begin
            if (redirectIn) begin
               pendKindNext  = redirectKind_t'(selKind);
               pendValueNext = selValue;
               stateNext     = REDIRECT;
            end else if (!stall) begin
               stateNext = FETCH;
            end
         end
         REDIRECT: begin
            pendKindNext  = NONE;
            pendValueNext = '0;
            stateNext     = stall ? STALL : FETCH;
         end
         default: begin
            stateNext     = BOOT;
            pendKindNext  = NONE;
            pendValueNext = '0;
         end
      endcase
   end

   // Output decode: handshake, PC strobes and flush, from state plus this cycle's inputs.
   always_comb begin
      imemReq       = 1'b0;
      pcWriteEnable = 1'b0;
      pcWriteAdd    = 1'b0;
      pcCountEnable = 1'b0;
      pcDataIn      = '0;
      flush         = 1'b0;
      busy          = (stateReg != FETCH);
      case (stateReg)
         FETCH: begin
            imemReq = 1'b1;
            if (imemAck) begin
               if (redirectIn) begin
                  flush = 1'b1;
               end else begin
                  pcCountEnable = 1'b1;
               end
            end
         end
         DRAIN: begin
            imemReq = 1'b1;
            flush   = imemAck;
         end
         REDIRECT: begin
            // Branches are PC-relative (the PC register subtracts the increment itself).
            pcWriteEnable = 1'b1;
            pcWriteAdd    = (pendKindReg == BRANCH);
            pcDataIn      = pendValueReg;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// ack/stall/redirect traffic, all checked against a transaction-level model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        imemReq;
   logic        imemAck;
   logic        stall;
   logic        branchTaken;
   logic [31:0] branchOffset;
   logic        jumpValid;
   logic [31:0] jumpTarget;
   logic        trapValid;
   logic        pcWriteEnable;
   logic        pcWriteAdd;
   logic        pcCountEnable;
   logic [31:0] pcDataIn;
   logic        flush;
   logic        busy;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .imemReq       (imemReq),
      .imemAck       (imemAck),
      .stall         (stall),
      .branchTaken   (branchTaken),
      .branchOffset  (branchOffset),
      .jumpValid     (jumpValid),
      .jumpTarget    (jumpTarget),
      .trapValid     (trapValid),
      .pcWriteEnable (pcWriteEnable),
      .pcWriteAdd    (pcWriteAdd),
      .pcCountEnable (pcCountEnable),
      .pcDataIn      (pcDataIn),
      .flush         (flush),
      .busy          (busy)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: PC register fed by the strobes, plus the expected fetch stream.
   logic [31:0] pcModel;
   logic [31:0] expAddr;
   logic [31:0] winVal;
   logic [31:0] winTarget;
   int          winKind;
   bit          winOpen;
   bit          expReq;
   bit          expWe;
   bit          inBoot;

   // Values seen in the most recent step, for directed checks.
   bit          lastReq, lastFlush, lastWe, lastAdd, lastBusy;
   logic [31:0] lastData;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      pcModel = '0;
      expAddr = '0;
      winOpen = 1'b0;
      winKind = 0;
      expReq  = 1'b0;
      expWe   = 1'b0;
      inBoot  = 1'b1;
   endtask

   task automatic checkResetOutputs();
      chk1 ("rst_imemReq", imemReq, 1'b0);
      chk1 ("rst_flush", flush, 1'b0);
      chk1 ("rst_pcWriteEnable", pcWriteEnable, 1'b0);
      chk1 ("rst_pcWriteAdd", pcWriteAdd, 1'b0);
      chk1 ("rst_pcCountEnable", pcCountEnable, 1'b0);
      chk32("rst_pcDataIn", pcDataIn, 32'h0);
      chk1 ("rst_busy", busy, 1'b1);
   endtask

   // One clock cycle: inputs are already driven; check at negedge, advance model at posedge.
   task automatic step();
      int          inc;
      logic [31:0] incVal;
      logic [31:0] incTarget;
      bit          winStart;
      bit          nReq;
      bit          nWe;
      bit          obsWe;
      bit          obsAdd;
      bit          obsCnt;
      logic [31:0] obsData;
      inc       = 0;
      incVal    = '0;
      incTarget = '0;
      @(negedge clk);
      winStart = winOpen;
      chk1("pcWriteEnable", pcWriteEnable, expWe);
      chk1("imemReq", imemReq, expReq);
      chk1("busy", busy, !(expReq && !winStart));
      chk1("weCountExclusive", pcWriteEnable & pcCountEnable, 1'b0);
      if (expWe) begin
         chk1 ("pcWriteAdd", pcWriteAdd, winKind == 1);
         chk32("pcDataIn", pcDataIn, winVal);
         chk1 ("flushInRedirect", flush, 1'b0);
         chk1 ("countInRedirect", pcCountEnable, 1'b0);
         expAddr = winTarget;
         winOpen = 1'b0;
         nReq    = !stall;
         nWe     = 1'b0;
      end else begin
         if (trapValid) begin
            inc = 3; incVal = 32'h0000_0010; incTarget = 32'h0000_0010;
         end else if (jumpValid) begin
            inc = 2; incVal = jumpTarget; incTarget = jumpTarget;
         end else if (branchTaken) begin
            inc = 1; incVal = branchOffset; incTarget = pcModel + branchOffset - 32'd4;
         end
         if (inc != 0 && !inBoot) begin
            if (!winOpen || inc > winKind) begin
               winOpen   = 1'b1;
               winKind   = inc;
               winVal    = incVal;
               winTarget = incTarget;
            end
         end
         chk1("flush", flush, expReq && imemAck && winOpen);
         chk1("pcCountEnable", pcCountEnable, expReq && imemAck && !winOpen);
         if (expReq && imemAck && !winOpen) begin
            chk32("fetchAddr", pcModel, expAddr);
            expAddr = expAddr + 32'd4;
         end
         nWe = winOpen && (!expReq || imemAck);
         if (inBoot)       nReq = 1'b1;
         else if (winOpen) nReq = expReq && !imemAck;
         else if (expReq)  nReq = !(imemAck && stall);
         else              nReq = !stall;
      end
      obsWe     = pcWriteEnable;
      obsAdd    = pcWriteAdd;
      obsCnt    = pcCountEnable;
      obsData   = pcDataIn;
      lastReq   = imemReq;
      lastFlush = flush;
      lastWe    = pcWriteEnable;
      lastAdd   = pcWriteAdd;
      lastData  = pcDataIn;
      lastBusy  = busy;
      $display("cyc=%0d req=%b ack=%b stall=%b br=%b jmp=%b trap=%b flush=%b cnt=%b we=%b add=%b data=%h pc=%h",
               cyc, imemReq, imemAck, stall, branchTaken, jumpValid, trapValid,
               flush, pcCountEnable, pcWriteEnable, pcWriteAdd, pcDataIn, pcModel);
      @(posedge clk);
      if (obsWe)       pcModel = obsAdd ? (pcModel + obsData - 32'd4) : obsData;
      else if (obsCnt) pcModel = pcModel + 32'd4;
      expReq = nReq;
      expWe  = nWe;
      inBoot = 1'b0;
      cyc++;
      #1;
      branchTaken = 1'b0;
      jumpValid   = 1'b0;
      trapValid   = 1'b0;
   endtask

   initial begin
      int r;
      reset        = 1'b1;
      imemAck      = 1'b0;
      stall        = 1'b0;
      branchTaken  = 1'b0;
      branchOffset = '0;
      jumpValid    = 1'b0;
      jumpTarget   = '0;
      trapValid    = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      checkResetOutputs();
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Boot then back-to-back fetches with ack tied high: PC 0, 4, 8, 12.
      step();
      chk1("bootReq", lastReq, 1'b0);
      imemAck = 1'b1;
      repeat (4) step();
      chk32("seqPc", pcModel, 32'd16);

      // Ack withheld for three cycles: request held, a single count on ack.
      imemAck = 1'b0;
      repeat (3) step();
      chk1("heldReq", lastReq, 1'b1);
      imemAck = 1'b1;
      step();
      chk32("ackPc", pcModel, 32'd20);

      // Branch of -8 raised while PC=0x20 with a same-cycle ack.
      for (int i = 0; i < 16 && pcModel != 32'h20; i++) step();
      branchTaken  = 1'b1;
      branchOffset = 32'hFFFF_FFF8;
      step();
      chk1("brFlush", lastFlush, 1'b1);
      step();
      chk1 ("brWe", lastWe, 1'b1);
      chk1 ("brAdd", lastAdd, 1'b1);
      chk32("brData", lastData, 32'hFFFF_FFF8);
      chk32("brPc", pcModel, 32'h14);
      step();

      // Jump and trap together with no ack: drain, flush on ack, trap wins.
      imemAck    = 1'b0;
      jumpValid  = 1'b1;
      jumpTarget = 32'h100;
      trapValid  = 1'b1;
      step();
      step();
      imemAck = 1'b1;
      step();
      chk1("trapFlush", lastFlush, 1'b1);
      imemAck = 1'b0;
      step();
      chk1 ("trapWe", lastWe, 1'b1);
      chk1 ("trapAdd", lastAdd, 1'b0);
      chk32("trapData", lastData, 32'h10);
      chk32("trapPc", pcModel, 32'h10);
      imemAck = 1'b1;
      step();

      // Stall at ack, branch while stalled, stall persists through the redirect.
      stall = 1'b1;
      step();
      step();
      chk1("stallReq", lastReq, 1'b0);
      branchTaken  = 1'b1;
      branchOffset = 32'h40;
      step();
      step();
      chk1("stallRedirWe", lastWe, 1'b1);
      step();
      chk1("restallReq", lastReq, 1'b0);
      stall = 1'b0;
      step();
      step();
      chk1("resumeReq", lastReq, 1'b1);

      // Asynchronous reset between edges while draining a jump.
      imemAck    = 1'b0;
      jumpValid  = 1'b1;
      jumpTarget = 32'h200;
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      checkResetOutputs();
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      chk1("rebootReq", lastReq, 1'b0);
      chk1("rebootBusy", lastBusy, 1'b1);
      imemAck = 1'b1;
      step();

      // Random traffic, including redirects that land in ignored cycles.
      for (int n = 0; n < 1500; n++) begin
         imemAck = ($urandom_range(0, 9) < 7);
         stall   = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 9) == 0) begin
            r            = $urandom_range(1, 7);
            trapValid    = r[2];
            jumpValid    = r[1];
            branchTaken  = r[0];
            jumpTarget   = $urandom & 32'hFFFF_FFFC;
            branchOffset = ($urandom_range(0, 64) * 4) - 128;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
